// File: rtl/fre_meas_ctrl_pkg.sv
// Shared definitions for the frequency-measurement path: state encoding and value limits.
// Also imported by the BCD and display blocks so their widths track the measured value.
package fre_meas_ctrl_pkg;

    localparam int unsigned FRE_W   = 14;
    localparam int unsigned MAX_FRE = 9999;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGate  = 3'd1,
        StLatch = 3'd2,
        StConv  = 3'd3,
        StHold  = 3'd4
    } state_e;

endpackage

// File: rtl/sig_edge_det.sv
// Two-flop synchroniser for the asynchronous DDS address MSB, plus a third flop so that a
// falling edge (previous 1, current 0) can be detected on synchronised data.
module sig_edge_det (
    input  logic signal,
    input  logic rst,
    input  logic din,
    output logic fall
);

    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge signal) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Cleared to 0 on reset, so settling after reset cannot fake an edge.
    assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/fre_meas_ctrl.sv
// Gate-window frequency counter: counts falling edges of the DDS address MSB over a fixed
// number of clock cycles, latches the count, and hands it to the BCD converter.
module fre_meas_ctrl
    import fre_meas_ctrl_pkg::*;
#(
    parameter int unsigned GATE_TICKS   = 10000,
    parameter int unsigned HOLD_TICKS   = 10000,
    parameter int unsigned CONV_TIMEOUT = 64,
    parameter int unsigned MAX_CNT      = MAX_FRE
) (
    input  logic             signal,
    input  logic             rst,
    input  logic             en,
    input  logic             addr_msb,
    input  logic             conv_done,
    output logic             conv_start,
    output logic [FRE_W-1:0] fre_out,
    output logic             fre_valid,
    output logic             ovf,
    output logic             conv_err,
    output logic             gate_active
);

    localparam logic [FRE_W-1:0] CntMax = FRE_W'(MAX_CNT);

    logic fall;

    state_e           state_q, state_d;
    logic [31:0]      tick_q, tick_d;
    logic [FRE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_int_q, ovf_int_d;
    logic [FRE_W-1:0] fre_out_q, fre_out_d;
    logic             ovf_q, ovf_d;
    logic             conv_err_q, conv_err_d;
    logic             conv_start_q, conv_start_d;
    logic             fre_valid_q, fre_valid_d;
    logic             gate_active_q, gate_active_d;

    sig_edge_det u_sig_edge_det (
        .signal (signal),
        .rst    (rst),
        .din    (addr_msb),
        .fall   (fall)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        edge_cnt_d   = edge_cnt_q;
        ovf_int_d    = ovf_int_q;
        fre_out_d    = fre_out_q;
        ovf_d        = ovf_q;
        conv_err_d   = conv_err_q;
        conv_start_d = 1'b0;
        fre_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tick_d     = '0;
                edge_cnt_d = '0;
                ovf_int_d  = 1'b0;
                if (en) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (fall) begin
                    if (edge_cnt_q == CntMax) begin
                        ovf_int_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + FRE_W'(1);
                    end
                end
                if (tick_q == GATE_TICKS - 1) begin
                    tick_d  = '0;
                    state_d = StLatch;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            StLatch: begin
                fre_out_d    = edge_cnt_q;
                ovf_d        = ovf_int_q;
                tick_d       = '0;
                conv_start_d = 1'b1;
                state_d      = StConv;
            end
            StConv: begin
                if (conv_done) begin
                    fre_valid_d = 1'b1;
                    tick_d      = '0;
                    state_d     = StHold;
                end else if (tick_q == CONV_TIMEOUT - 1) begin
                    conv_err_d = 1'b1;
                    tick_d     = '0;
                    state_d    = StHold;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            StHold: begin
                if (tick_q == HOLD_TICKS - 1) begin
                    tick_d     = '0;
                    edge_cnt_d = '0;
                    ovf_int_d  = 1'b0;
                    state_d    = StGate;
                end else begin
                    tick_d = tick_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Dropping enable aborts the window; the last published results stay put.
        if (!en) begin
            state_d      = StIdle;
            tick_d       = '0;
            edge_cnt_d   = '0;
            ovf_int_d    = 1'b0;
            fre_out_d    = fre_out_q;
            ovf_d        = ovf_q;
            conv_err_d   = conv_err_q;
            conv_start_d = 1'b0;
            fre_valid_d  = 1'b0;
        end

        gate_active_d = (state_d == StGate);
    end

    always_ff @(posedge signal) begin
        if (rst) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            edge_cnt_q    <= '0;
            ovf_int_q     <= 1'b0;
            fre_out_q     <= '0;
            ovf_q         <= 1'b0;
            conv_err_q    <= 1'b0;
            conv_start_q  <= 1'b0;
            fre_valid_q   <= 1'b0;
            gate_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_int_q     <= ovf_int_d;
            fre_out_q     <= fre_out_d;
            ovf_q         <= ovf_d;
            conv_err_q    <= conv_err_d;
            conv_start_q  <= conv_start_d;
            fre_valid_q   <= fre_valid_d;
            gate_active_q <= gate_active_d;
        end
    end

    assign conv_start  = conv_start_q;
    assign fre_out     = fre_out_q;
    assign fre_valid   = fre_valid_q;
    assign ovf         = ovf_q;
    assign conv_err    = conv_err_q;
    assign gate_active = gate_active_q;

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// Directed bench for fre_meas_ctrl with short windows; a second instance has its count
// ceiling lowered to 40 so saturation can be reached inside a 100-cycle gate.
module tb_fre_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, addr_msb, conv_done;
    logic        conv_start, fre_valid, ovf, conv_err, gate_active;
    logic [13:0] fre_out;

    logic        en2, addr2, done2;
    logic        conv_start2, fre_valid2, ovf2, conv_err2, gate_active2;
    logic [13:0] fre_out2;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          cs, fv, ga;

    always #5 clk = ~clk;

    fre_meas_ctrl #(
        .GATE_TICKS   (100),
        .HOLD_TICKS   (20),
        .CONV_TIMEOUT (8)
    ) dut (
        .signal      (clk),
        .rst         (rst),
        .en          (en),
        .addr_msb    (addr_msb),
        .conv_done   (conv_done),
        .conv_start  (conv_start),
        .fre_out     (fre_out),
        .fre_valid   (fre_valid),
        .ovf         (ovf),
        .conv_err    (conv_err),
        .gate_active (gate_active)
    );

    fre_meas_ctrl #(
        .GATE_TICKS   (100),
        .HOLD_TICKS   (20),
        .CONV_TIMEOUT (8),
        .MAX_CNT      (40)
    ) dut_max (
        .signal      (clk),
        .rst         (rst),
        .en          (en2),
        .addr_msb    (addr2),
        .conv_done   (done2),
        .conv_start  (conv_start2),
        .fre_out     (fre_out2),
        .fre_valid   (fre_valid2),
        .ovf         (ovf2),
        .conv_err    (conv_err2),
        .gate_active (gate_active2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_edges(input int n);
        for (int k = 0; k < n; k++) begin
            addr_msb = 1'b1;
            step();
            addr_msb = 1'b0;
            step();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fre_out"}, 32'(fre_out), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_conv_err"}, 32'(conv_err), 0);
        check({tag, "_conv_start"}, 32'(conv_start), 0);
        check({tag, "_fre_valid"}, 32'(fre_valid), 0);
        check({tag, "_gate_active"}, 32'(gate_active), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; addr_msb = 1'b0; conv_done = 1'b0;
        en2 = 1'b0; addr2 = 1'b0; done2 = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        // Saturation: toggle every cycle for a whole window against a ceiling of 40.
        en2 = 1'b1;
        for (int k = 0; k < 5 && gate_active2 !== 1'b1; k++) step();
        check("sat_gate_start", 32'(gate_active2), 1);
        for (int k = 0; k < 100; k++) begin
            addr2 = ~addr2;
            step();
        end
        addr2 = 1'b0;
        for (int k = 0; k < 60 && conv_start2 !== 1'b1; k++) step();
        check("sat_conv_start", 32'(conv_start2), 1);
        check("sat_fre_out", 32'(fre_out2), 40);
        check("sat_ovf", 32'(ovf2), 1);
        check("sat_fre_valid", 32'(fre_valid2), 0);
        check("sat_conv_err", 32'(conv_err2), 0);
        en2 = 1'b0;

        // 37 edges, conv_done three cycles after conv_start.
        en = 1'b1;
        for (int k = 0; k < 5 && gate_active !== 1'b1; k++) step();
        check("w37_gate_start", 32'(gate_active), 1);
        drive_edges(37);
        for (int k = 0; k < 150 && conv_start !== 1'b1; k++) step();
        check("w37_conv_start", 32'(conv_start), 1);
        check("w37_fre_out", 32'(fre_out), 37);
        check("w37_ovf", 32'(ovf), 0);
        cs = 0; fv = 0;
        for (int i = 1; i <= 25; i++) begin
            conv_done = (i == 3);
            step();
            cs += int'(conv_start);
            fv += int'(fre_valid);
            if (i == 1) check("w37_start_width", 32'(conv_start), 0);
            if (i == 3) check("w37_valid_timing", 32'(fre_valid), 1);
        end
        conv_done = 1'b0;
        check("w37_extra_starts", 32'(cs), 0);
        check("w37_valid_pulses", 32'(fv), 1);
        check("w37_conv_err", 32'(conv_err), 0);
        check("w37_back_to_gate", 32'(gate_active), 1);

        // Abort mid-gate after 12 edges.
        drive_edges(12);
        repeat (4) step();
        en = 1'b0;
        step();
        check("abort_gate_off", 32'(gate_active), 0);
        check("abort_fre_out", 32'(fre_out), 37);
        cs = 0; ga = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            cs += int'(conv_start);
            ga += int'(gate_active);
        end
        check("idle_no_start", 32'(cs), 0);
        check("idle_no_gate", 32'(ga), 0);
        check("idle_fre_out", 32'(fre_out), 37);

        // Reset during CONV.
        en = 1'b1;
        for (int k = 0; k < 5 && gate_active !== 1'b1; k++) step();
        drive_edges(37);
        for (int k = 0; k < 150 && conv_start !== 1'b1; k++) step();
        check("rst_conv_start", 32'(conv_start), 1);
        check("rst_pre_fre_out", 32'(fre_out), 37);
        rst = 1'b1;
        step();
        check_all_zero("rst_conv");
        rst = 1'b0;

        // From reset release: edge on last gate cycle (counted), timeout, then edge on LATCH.
        cs = 0; fv = 0;
        for (int j = 1; j <= 233; j++) begin
            addr_msb = (j == 98 || j == 228);
            step();
            if (j <= 101) cs += int'(conv_start);
            fv += int'(fre_valid);
            if (j == 1)   check("post_rst_gate", 32'(gate_active), 1);
            if (j == 102) check("last_cycle_start", 32'(conv_start), 1);
            if (j == 102) check("last_cycle_counted", 32'(fre_out), 1);
            if (j == 109) check("tmo_not_yet", 32'(conv_err), 0);
            if (j == 110) check("tmo_conv_err", 32'(conv_err), 1);
            if (j == 129) check("hold_no_gate", 32'(gate_active), 0);
            if (j == 130) check("hold_to_gate", 32'(gate_active), 1);
            if (j == 231) check("latch_start", 32'(conv_start), 1);
            if (j == 232) check("latch_edge_ignored", 32'(fre_out), 0);
            if (j == 233) check("conv_err_sticky", 32'(conv_err), 1);
        end
        addr_msb = 1'b0;
        check("no_start_before_window", 32'(cs), 0);
        check("tmo_no_valid", 32'(fv), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
